arbitrated_memory_controller: RTL and testbench
===============================================

# arbitrated_memory_controller

Parametrised successor to the single-cycle instruction/data memory controller. It arbitrates the L1 instruction and L1 data clients onto one shared, fixed-latency backing-memory port plus a single-cycle peripheral port, using valid/ready handshakes instead of combinational stalls. It also adds byte-enable writes, ROM write protection, out-of-range error reporting and starvation-bounded data-priority arbitration. It sits between the L1 caches and the ROM/RAM/peripheral blocks.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width; multiple of 8
- ROM_SIZE, 32, ROM words (word index 0..ROM_SIZE-1)
- RAM_SIZE, 32, RAM words (word index ROM_SIZE..ROM_SIZE+RAM_SIZE-1)
- LATENCY, 2, backing-memory read latency in cycles, ≥1
- STARVE_LIMIT, 4, consecutive instruction losses before the instruction port is forced to win, ≥1

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request
- i_address  in  ADDR_WIDTH  instruction byte address
- i_ready  out  1  instruction request accepted this cycle
- i_valid  out  1  one-cycle response strobe
- i_rdata  out  DATA_WIDTH  fetched word, valid with i_valid
- i_err  out  1  error flag, valid with i_valid
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_address  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  byte enables for writes
- d_ready, d_valid, d_err  out  1  as the instruction port
- d_rdata  out  DATA_WIDTH  read word; 0 for writes
- mem_en  out  1  one-cycle backing-memory access strobe
- mem_we  out  1  write qualifier
- mem_address  out  ADDR_WIDTH-2  word index
- mem_wdata  out  DATA_WIDTH  write data
- mem_be  out  DATA_WIDTH/8  byte enables
- mem_rdata  in  DATA_WIDTH  valid exactly LATENCY cycles after the mem_en cycle
- per_sel, per_we  out  1  peripheral strobe and write qualifier
- per_address  out  ADDR_WIDTH  byte address (top bit cleared)
- per_wdata  out  DATA_WIDTH  peripheral write data
- per_rdata  in  DATA_WIDTH  peripheral read data, sampled at the end of the per_sel cycle

## Operation
- Address decode on the latched address:
  - bit ADDR_WIDTH-1 = 1: peripheral.
  - Otherwise word index w = address>>2. w < ROM_SIZE is ROM; w < ROM_SIZE+RAM_SIZE is RAM; anything else is out of range.
  - The low two address bits are ignored.
- Errors are reported with err=1 and no backend or peripheral strobe; the write is suppressed:
  - data write to ROM;
  - out-of-range address on either port.
- Instruction fetches never write; mem_be is driven all-ones for reads.
- Arbitration is evaluated only in IDLE.
  - If only one port requests, that port wins.
  - If both request, data wins unless starve_cnt == STARVE_LIMIT, in which case instruction wins.
  - starve_cnt increments (saturating) when the instruction port requests and loses; it clears when the instruction port is granted.
- The winner's ready is driven high combinationally in IDLE. Acceptance is req && ready; the request fields are latched at that edge.
- FSM:
  - IDLE → ISSUE on acceptance.
  - ISSUE: drive mem_en or per_sel for exactly one cycle, or neither on error. Memory access → WAIT. Peripheral or error → RESP.
  - WAIT: count LATENCY-1 further cycles, capture mem_rdata on the last of them, then → RESP.
  - RESP: the owning port's valid, rdata and err are driven for one cycle, then → IDLE.
- Only one transaction is in flight at a time. ready is low in every state except IDLE.

## Timing
- Reset (asynchronous, any state): FSM → IDLE, starve_cnt → 0, in-flight transaction dropped with no valid. All outputs are 0: ready, valid, err, rdata, mem_*, per_*.
- Acceptance at edge E0:
  - mem_en is high in cycle E0–E1.
  - mem_rdata is sampled at edge E(1+LATENCY).
  - valid is high in cycle E(1+LATENCY)–E(2+LATENCY).
  - Earliest next acceptance is at edge E(3+LATENCY).
- Peripheral or error transaction: valid is high in cycle E1–E2; next acceptance at E3.
- Write responses assert valid with rdata=0.
- A req deasserted while not ready is simply not serviced; there is no queuing.

## Test plan
- Reset mid-WAIT (LATENCY=2, data read outstanding), reset_n low for 1 cycle → no d_valid ever, all outputs 0, next i_req accepted in IDLE.
- Data read at 0x00000080 with ROM_SIZE=32 → mem_address=32, mem_en at E0+1, d_valid at E0+3 with d_rdata=mem_rdata, d_err=0.
- Data write 0x0000000C, d_be=4'b0011 → no mem_en, d_valid with d_err=1 one cycle after ISSUE.
- i_req and d_req held high continuously with STARVE_LIMIT=4 → grant sequence D,D,D,D,I, repeating.
- Peripheral write to 0x80000004, d_wdata=0xDEADBEEF → per_sel=per_we=1 for one cycle, per_address=0x00000004; d_valid in the following cycle.
- Instruction fetch at word index ROM_SIZE+RAM_SIZE → i_err=1, i_rdata=0, no mem_en.

Source files
------------

// File: rtl/arbitrated_memory_controller_if.sv
// arbitrated_memory_controller_if: client, backing-memory and peripheral signals of the memory controller
interface arbitrated_memory_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      i_req;
    logic [ADDR_WIDTH-1:0]     i_address;
    logic                      i_ready;
    logic                      i_valid;
    logic [DATA_WIDTH-1:0]     i_rdata;
    logic                      i_err;
    logic                      d_req;
    logic                      d_we;
    logic [ADDR_WIDTH-1:0]     d_address;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_be;
    logic                      d_ready;
    logic                      d_valid;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      d_err;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_WIDTH-3:0]     mem_address;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      per_sel;
    logic                      per_we;
    logic [ADDR_WIDTH-1:0]     per_address;
    logic [DATA_WIDTH-1:0]     per_wdata;
    logic [DATA_WIDTH-1:0]     per_rdata;

    modport master (
        output i_req, i_address, d_req, d_we, d_address, d_wdata, d_be, mem_rdata, per_rdata,
        input  i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err,
               mem_en, mem_we, mem_address, mem_wdata, mem_be,
               per_sel, per_we, per_address, per_wdata
    );

    modport slave (
        input  i_req, i_address, d_req, d_we, d_address, d_wdata, d_be, mem_rdata, per_rdata,
        output i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err,
               mem_en, mem_we, mem_address, mem_wdata, mem_be,
               per_sel, per_we, per_address, per_wdata
    );
endinterface

// File: rtl/arbitrated_memory_controller.sv
// arbitrated_memory_controller: arbitrates instruction/data clients onto a fixed-latency memory port and a peripheral port
module arbitrated_memory_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROM_SIZE     = 32,
    parameter int RAM_SIZE     = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic clock,
    input logic reset_n,
    arbitrated_memory_controller_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH-3:0] rom_end = (ADDR_WIDTH-2)'(ROM_SIZE);
    localparam logic [ADDR_WIDTH-3:0] ram_end = (ADDR_WIDTH-2)'(ROM_SIZE + RAM_SIZE);
    localparam logic [SW-1:0] starve_max = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] wait_last = CW'(LATENCY - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic [SW-1:0]         starve_cnt;
    logic [CW-1:0]         wait_cnt;
    logic                  own_d;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BW-1:0]         lat_be;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  idle;
    logic                  grant_d;
    logic                  grant_i;
    logic                  is_per;
    logic                  err;
    logic [ADDR_WIDTH-3:0] widx;

    // ready is gated by reset so nothing is offered while reset is held
    assign idle    = reset_n && state == IDLE;
    assign grant_d = bus.d_req && !(bus.i_req && starve_cnt == starve_max);
    assign grant_i = bus.i_req && !grant_d;
    assign bus.d_ready = idle && grant_d;
    assign bus.i_ready = idle && grant_i;

    // decode always works on the latched request; lat_we is only ever set by the data port
    assign is_per = lat_addr[ADDR_WIDTH-1];
    assign widx   = lat_addr[ADDR_WIDTH-1:2];
    assign err    = !is_per && (widx >= ram_end || (lat_we && widx < rom_end));

    assign bus.mem_en      = state == ISSUE && !is_per && !err;
    assign bus.mem_we      = bus.mem_en && lat_we;
    assign bus.mem_address = bus.mem_en ? widx : '0;
    assign bus.mem_wdata   = bus.mem_we ? lat_wdata : '0;
    assign bus.mem_be      = bus.mem_en ? (lat_we ? lat_be : '1) : '0;
    assign bus.per_sel     = state == ISSUE && is_per;
    assign bus.per_we      = bus.per_sel && lat_we;
    assign bus.per_address = bus.per_sel ? {1'b0, lat_addr[ADDR_WIDTH-2:0]} : '0;
    assign bus.per_wdata   = bus.per_we ? lat_wdata : '0;
    assign bus.i_valid     = state == RESP && !own_d;
    assign bus.d_valid     = state == RESP && own_d;
    assign bus.i_rdata     = bus.i_valid ? rdata : '0;
    assign bus.d_rdata     = bus.d_valid ? rdata : '0;
    assign bus.i_err       = bus.i_valid && err;
    assign bus.d_err       = bus.d_valid && err;

    // starvation counter: saturating count of instruction losses, cleared on an instruction grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_cnt <= '0;
        else if (idle && bus.i_req) starve_cnt <= grant_i ? '0 : (starve_cnt == starve_max ? starve_cnt : starve_cnt + 1'b1);
    end

    // transaction FSM: latch on acceptance, strobe once, wait out the memory latency, respond once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            own_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.d_ready || bus.i_ready) begin
                    state     <= ISSUE;
                    own_d     <= grant_d;
                    lat_we    <= grant_d && bus.d_we;
                    lat_addr  <= grant_d ? bus.d_address : bus.i_address;
                    lat_wdata <= grant_d ? bus.d_wdata : '0;
                    lat_be    <= grant_d ? bus.d_be : '1;
                    rdata     <= '0;
                end
                ISSUE: begin
                    state    <= bus.mem_en ? WAIT : RESP;
                    wait_cnt <= '0;
                    if (bus.per_sel && !lat_we) rdata <= bus.per_rdata;
                end
                WAIT: if (wait_cnt == wait_last) begin
                    state <= RESP;
                    if (!lat_we) rdata <= bus.mem_rdata;
                end else wait_cnt <= wait_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitrated_memory_controller.sv
// tb_arbitrated_memory_controller: directed checks of decode, timing, errors, reset and starvation arbitration
module tb_arbitrated_memory_controller;
    logic clock;
    logic reset_n;
    int vectors;
    int miscompares;
    logic [31:0] pipe0;
    logic [31:0] pipe1;

    arbitrated_memory_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    arbitrated_memory_controller #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROM_SIZE(32), .RAM_SIZE(32), .LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // backing memory: returns 0xA5000000|index only in the cycle exactly two cycles after mem_en
    always @(posedge clock) begin
        pipe0 <= bus.mem_en ? (32'hA500_0000 | {2'b00, bus.mem_address}) : 32'h0;
        pipe1 <= pipe0;
    end
    assign bus.mem_rdata = pipe1;
    assign bus.per_rdata = bus.per_sel ? 32'hCAFE_F00D : 32'h0;

    task automatic idle_inputs;
        bus.i_req = 0; bus.i_address = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_address = 0; bus.d_wdata = 0; bus.d_be = 0;
    endtask

    task automatic test_reset;
        reset_n = 0;
        idle_inputs();
        bus.i_req = 1; bus.d_req = 1;
        @(negedge clock); #1;
        vectors++;
        if ({bus.i_ready, bus.d_ready, bus.i_valid, bus.d_valid, bus.i_err, bus.d_err, bus.mem_en, bus.mem_we, bus.per_sel, bus.per_we} !== 10'b0) begin
            miscompares++; $display("FAIL reset_flags got %b want 0", {bus.i_ready, bus.d_ready, bus.i_valid, bus.d_valid, bus.i_err, bus.d_err, bus.mem_en, bus.mem_we, bus.per_sel, bus.per_we});
        end
        vectors++;
        if ({bus.i_rdata, bus.d_rdata, bus.mem_address, bus.mem_wdata, bus.mem_be, bus.per_address, bus.per_wdata} !== '0) begin
            miscompares++; $display("FAIL reset_buses got nonzero i_rdata=%h d_rdata=%h mem_address=%h per_address=%h", bus.i_rdata, bus.d_rdata, bus.mem_address, bus.per_address);
        end
        idle_inputs();
        @(negedge clock); reset_n = 1;
        @(negedge clock);
    endtask

    task automatic test_data_read;
        @(negedge clock);
        bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h0000_0080; #1;
        vectors++;
        if (bus.d_ready !== 1'b1) begin miscompares++; $display("FAIL rd_ready got %b want 1", bus.d_ready); end
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.mem_address, bus.mem_be, bus.per_sel} !== {1'b1, 1'b0, 30'd32, 4'hF, 1'b0}) begin
            miscompares++; $display("FAIL rd_issue got en=%b we=%b addr=%0d be=%h want en=1 we=0 addr=32 be=f", bus.mem_en, bus.mem_we, bus.mem_address, bus.mem_be);
        end
        @(negedge clock);
        @(negedge clock); #1;
        vectors++;
        if ({bus.mem_en, bus.d_valid} !== 2'b00) begin miscompares++; $display("FAIL rd_wait got en=%b valid=%b want 0 0", bus.mem_en, bus.d_valid); end
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata, bus.i_valid} !== {1'b1, 1'b0, 32'hA500_0020, 1'b0}) begin
            miscompares++; $display("FAIL rd_resp got valid=%b err=%b rdata=%h want 1 0 a5000020", bus.d_valid, bus.d_err, bus.d_rdata);
        end
        @(negedge clock);
        bus.i_req = 1; bus.i_address = 32'h0000_0010; #1;
        vectors++;
        if ({bus.i_ready, bus.d_valid} !== 2'b10) begin miscompares++; $display("FAIL rd_next_idle got ready=%b valid=%b want 1 0", bus.i_ready, bus.d_valid); end
        idle_inputs();
    endtask

    task automatic test_ram_write;
        @(negedge clock);
        bus.d_req = 1; bus.d_we = 1; bus.d_address = 32'h0000_0084; bus.d_wdata = 32'h1234_5678; bus.d_be = 4'b0011;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.mem_we, bus.mem_address, bus.mem_be, bus.mem_wdata} !== {1'b1, 1'b1, 30'd33, 4'b0011, 32'h1234_5678}) begin
            miscompares++; $display("FAIL wr_issue got en=%b we=%b addr=%0d be=%b wdata=%h want 1 1 33 0011 12345678", bus.mem_en, bus.mem_we, bus.mem_address, bus.mem_be, bus.mem_wdata);
        end
        @(negedge clock);
        @(negedge clock);
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++; $display("FAIL wr_resp got valid=%b err=%b rdata=%h want 1 0 0", bus.d_valid, bus.d_err, bus.d_rdata);
        end
        @(negedge clock);
    endtask

    task automatic test_rom_write;
        @(negedge clock);
        bus.d_req = 1; bus.d_we = 1; bus.d_address = 32'h0000_000C; bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'b0011;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.per_sel, bus.d_valid} !== 3'b000) begin
            miscompares++; $display("FAIL rom_issue got en=%b sel=%b valid=%b want 0 0 0", bus.mem_en, bus.per_sel, bus.d_valid);
        end
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            miscompares++; $display("FAIL rom_resp got valid=%b err=%b rdata=%h want 1 1 0", bus.d_valid, bus.d_err, bus.d_rdata);
        end
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.mem_en} !== 3'b000) begin
            miscompares++; $display("FAIL rom_after got valid=%b err=%b en=%b want 0 0 0", bus.d_valid, bus.d_err, bus.mem_en);
        end
    endtask

    task automatic test_periph_write;
        @(negedge clock);
        bus.d_req = 1; bus.d_we = 1; bus.d_address = 32'h8000_0004; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.per_sel, bus.per_we, bus.per_address, bus.per_wdata, bus.mem_en, bus.d_valid} !== {1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL per_wr_issue got sel=%b we=%b addr=%h wdata=%h en=%b want 1 1 4 deadbeef 0", bus.per_sel, bus.per_we, bus.per_address, bus.per_wdata, bus.mem_en);
        end
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata, bus.per_sel} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            miscompares++; $display("FAIL per_wr_resp got valid=%b err=%b rdata=%h sel=%b want 1 0 0 0", bus.d_valid, bus.d_err, bus.d_rdata, bus.per_sel);
        end
        @(negedge clock);
    endtask

    task automatic test_periph_read;
        bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h8000_0010;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.per_sel, bus.per_we, bus.per_address} !== {1'b1, 1'b0, 32'h10}) begin
            miscompares++; $display("FAIL per_rd_issue got sel=%b we=%b addr=%h want 1 0 10", bus.per_sel, bus.per_we, bus.per_address);
        end
        @(negedge clock); #1;
        vectors++;
        if ({bus.d_valid, bus.d_err, bus.d_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            miscompares++; $display("FAIL per_rd_resp got valid=%b err=%b rdata=%h want 1 0 cafef00d", bus.d_valid, bus.d_err, bus.d_rdata);
        end
        @(negedge clock);
    endtask

    task automatic test_oor_fetch;
        bus.i_req = 1; bus.i_address = 32'h0000_0100;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.per_sel} !== 2'b00) begin miscompares++; $display("FAIL oor_issue got en=%b sel=%b want 0 0", bus.mem_en, bus.per_sel); end
        @(negedge clock); #1;
        vectors++;
        if ({bus.i_valid, bus.i_err, bus.i_rdata, bus.d_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            miscompares++; $display("FAIL oor_resp got valid=%b err=%b rdata=%h want 1 1 0", bus.i_valid, bus.i_err, bus.i_rdata);
        end
        @(negedge clock);
        bus.i_req = 1; bus.i_address = 32'h0000_00FC;
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.mem_address} !== {1'b1, 30'd63}) begin
            miscompares++; $display("FAIL last_ram_issue got en=%b addr=%0d want 1 63", bus.mem_en, bus.mem_address);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid_wait;
        logic seen;
        seen = 0;
        @(negedge clock);
        bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h0000_0080;
        @(negedge clock); idle_inputs();
        @(negedge clock); reset_n = 0; #1;
        vectors++;
        if ({bus.mem_en, bus.d_valid, bus.d_ready, bus.i_ready, bus.d_rdata, bus.mem_address} !== '0) begin
            miscompares++; $display("FAIL midrst_outputs got en=%b valid=%b rdata=%h addr=%h want 0", bus.mem_en, bus.d_valid, bus.d_rdata, bus.mem_address);
        end
        @(negedge clock); reset_n = 1;
        for (int c = 0; c < 6; c++) begin
            #1; if (bus.d_valid || bus.mem_en) seen = 1;
            @(negedge clock);
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_valid got activity=%b want 0", seen); end
        bus.i_req = 1; bus.i_address = 32'h0000_0010; #1;
        vectors++;
        if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_accept got ready=%b want 1", bus.i_ready); end
        @(negedge clock); idle_inputs(); #1;
        vectors++;
        if ({bus.mem_en, bus.mem_address} !== {1'b1, 30'd4}) begin
            miscompares++; $display("FAIL midrst_fetch got en=%b addr=%0d want 1 4", bus.mem_en, bus.mem_address);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_starvation;
        logic grants [10];
        int n;
        n = 0;
        bus.i_req = 1; bus.i_address = 32'h0000_0010;
        bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h0000_0084;
        for (int c = 0; c < 200 && n < 10; c++) begin
            #1;
            if (bus.d_ready && bus.i_ready) begin miscompares++; vectors++; $display("FAIL starve_dual_ready got both ready want one"); end
            if (bus.d_ready) begin grants[n] = 1; n++; end
            else if (bus.i_ready) begin grants[n] = 0; n++; end
            if (bus.i_valid) begin
                vectors++;
                if (bus.i_rdata !== 32'hA500_0004) begin miscompares++; $display("FAIL starve_i_rdata got %h want a5000004", bus.i_rdata); end
            end
            if (bus.d_valid) begin
                vectors++;
                if (bus.d_rdata !== 32'hA500_0021) begin miscompares++; $display("FAIL starve_d_rdata got %h want a5000021", bus.d_rdata); end
            end
            @(negedge clock);
        end
        idle_inputs();
        vectors++;
        if (n !== 10) begin miscompares++; $display("FAIL starve_grant_count got %0d want 10", n); end
        for (int k = 0; k < n; k++) begin
            vectors++;
            if (grants[k] !== (k % 5 != 4)) begin
                miscompares++; $display("FAIL starve_grant_%0d got %s want %s", k, grants[k] ? "D" : "I", (k % 5 != 4) ? "D" : "I");
            end
        end
        repeat (6) @(negedge clock);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_data_read();
        test_ram_write();
        test_rom_write();
        test_periph_write();
        test_periph_read();
        test_oor_fetch();
        test_reset_mid_wait();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
